mult_div: RTL and testbench

MULT_DIV -- requirements
Module: mult_div

---
 rtl/mult_div.sv | 166 ++++++++++++++++
 tb/tb_mult_div.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div.sv
// rtl/mult_div.sv - 32-bit signed multiply/divide unit producing HI/LO
//
// Purpose:
//   Iterative signed multiply (radix-2 Booth) and signed divide (restoring
//   on magnitudes, signs applied at the end). One iteration per clock for
//   32 clocks, results written to HI/LO only on completion.
//
// Ports:
//   clock     in   1   rising-edge clock
//   reset     in   1   asynchronous active-low reset
//   start     in   1   operation request, sampled only in IDLE
//   op        in   1   0 = signed mult, 1 = signed div
//   a, b      in  32   operands (rs, rt), latched on accept
//   hi_out    out 32   HI register (product high / remainder)
//   lo_out    out 32   LO register (product low / quotient)
//   busy      out  1   high while iterating (RUN)
//   done      out  1   one-cycle completion pulse
//   div_zero  out  1   high with done when a divide had b == 0

module mult_div (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        op_r;
  // acc: Booth accumulator for mult, partial remainder for div.
  // It carries one guard bit above 32 so that subtracting a multiplicand of
  // -2^31 cannot wrap the sign used by the arithmetic shift.
  logic [32:0] acc;
  // mq: multiplier (shifting out) for mult, dividend/quotient for div.
  logic [31:0] mq;
  logic        q_1;
  // m: multiplicand for mult, divisor magnitude for div.
  logic [31:0] m;
  logic        q_neg;
  logic        r_neg;

  logic [32:0] acc_nx;
  logic [31:0] mq_nx;
  logic        q1_nx;
  logic [32:0] sum;
  logic [32:0] shifted;
  logic [33:0] diff;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  // Magnitudes as unsigned values; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude of -2^31.
  assign a_mag = a[31] ? (32'd0 - a) : a;
  assign b_mag = b[31] ? (32'd0 - b) : b;

  // One iteration step plus the final result it would produce.
  always_comb begin
    acc_nx  = acc;
    mq_nx   = mq;
    q1_nx   = q_1;
    sum     = acc;
    shifted = {acc[31:0], mq[31]};
    diff    = {1'b0, shifted} - {2'b00, m};
    res_hi  = 32'd0;
    res_lo  = 32'd0;
    if (!op_r) begin
      case ({mq[0], q_1})
        2'b01:   sum = acc + {m[31], m};
        2'b10:   sum = acc - {m[31], m};
        default: sum = acc;
      endcase
      acc_nx = {sum[32], sum[32:1]};
      mq_nx  = {sum[0], mq[31:1]};
      q1_nx  = mq[0];
      res_hi = acc_nx[31:0];
      res_lo = mq_nx;
    end else begin
      if (!diff[33]) begin
        acc_nx = diff[32:0];
        mq_nx  = {mq[30:0], 1'b1};
      end else begin
        acc_nx = shifted;
        mq_nx  = {mq[30:0], 1'b0};
      end
      res_lo = q_neg ? (32'd0 - mq_nx) : mq_nx;
      res_hi = r_neg ? (32'd0 - acc_nx[31:0]) : acc_nx[31:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      op_r     <= 1'b0;
      acc      <= 33'd0;
      mq       <= 32'd0;
      q_1      <= 1'b0;
      m        <= 32'd0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      hi_out   <= 32'd0;
      lo_out   <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r  <= op;
            cnt   <= 5'd0;
            acc   <= 33'd0;
            q_1   <= 1'b0;
            q_neg <= a[31] ^ b[31];
            r_neg <= a[31];
            mq    <= op ? a_mag : b;
            m     <= op ? b_mag : a;
            if (op && (b == 32'd0)) begin
              // Divide by zero skips RUN; HI/LO are left untouched.
              state    <= DONE;
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          acc <= acc_nx;
          mq  <= mq_nx;
          q_1 <= q1_nx;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            hi_out <= res_hi;
            lo_out <= res_lo;
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// tb/tb_mult_div.sv - self-checking bench for mult_div against an arithmetic reference

module tb_mult_div;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op    = 1'b0;
  logic [31:0] a     = 32'd0;
  logic [31:0] b     = 32'd0;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;
  logic        div_zero;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_hi  = 32'd0;
  logic [31:0] m_lo  = 32'd0;

  mult_div dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // {HI, LO} from plain 64-bit signed arithmetic.
  function automatic logic [63:0] ref_result(input logic o, input logic [31:0] x, input logic [31:0] y);
    longint sx;
    longint sy;
    longint q;
    longint r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!o) return sx * sy;
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'h0000_0000;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = 32'h7FFF_FFFF;
      4:       v = $urandom_range(0, 15);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic scramble_inputs();
    logic [31:0] r;
    r = $urandom;
    op = r[0];
    a  = $urandom;
    b  = $urandom;
  endtask

  // Called just after an edge; returns the edge index (accept = 1) at which
  // done was first seen high, bounded.
  task automatic wait_done(output int edges);
    edges = 1;
    while (done !== 1'b1 && edges < 40) begin
      @(posedge clock);
      #1;
      edges++;
    end
  endtask

  // Drives start now (caller is away from the edge), follows the op to done.
  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y);
    logic        dz;
    logic [63:0] e;
    int          lat;
    dz    = o && (y == 32'd0);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    scramble_inputs();
    if (!dz) check("busy_run", 64'(busy), 64'd1);
    wait_done(lat);
    check("latency", 64'(lat), dz ? 64'd1 : 64'd33);
    if (!dz) begin
      e    = ref_result(o, x, y);
      m_hi = e[63:32];
      m_lo = e[31:0];
    end
    check("hi", 64'(hi_out), 64'(m_hi));
    check("lo", 64'(lo_out), 64'(m_lo));
    check("div_zero", 64'(div_zero), 64'(dz));
    check("busy_done", 64'(busy), 64'd0);
    @(posedge clock);
    #1;
    check("done_pulse", 64'(done), 64'd0);
    check("dz_idle", 64'(div_zero), 64'd0);
  endtask

  initial begin
    int          lat;
    logic [31:0] r;
    logic [63:0] e;

    repeat (2) @(posedge clock);
    #1;
    check("rst_hi", 64'(hi_out), 64'd0);
    check("rst_lo", 64'(lo_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_zero), 64'd0);

    // Start on the very first edge after release.
    reset = 1'b1;
    run_op(1'b0, 32'h0000_0007, 32'hFFFF_FFFD);
    check("m7x-3_hi", 64'(hi_out), 64'hFFFF_FFFF);
    check("m7x-3_lo", 64'(lo_out), 64'hFFFF_FFEB);
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000);
    check("mmin2_hi", 64'(hi_out), 64'h4000_0000);
    check("mmin2_lo", 64'(lo_out), 64'h0000_0000);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mneg1_hi", 64'(hi_out), 64'h0);
    check("mneg1_lo", 64'(lo_out), 64'h1);
    run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    check("d-7/2_lo", 64'(lo_out), 64'hFFFF_FFFD);
    check("d-7/2_hi", 64'(hi_out), 64'hFFFF_FFFF);
    run_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFE);
    check("d7/-2_lo", 64'(lo_out), 64'hFFFF_FFFD);
    check("d7/-2_hi", 64'(hi_out), 64'h1);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    check("dovf_lo", 64'(lo_out), 64'h8000_0000);
    check("dovf_hi", 64'(hi_out), 64'h0);

    // Divide by zero must leave nonzero HI/LO untouched.
    run_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF1);
    run_op(1'b1, 32'h0000_0055, 32'h0000_0000);
    e = ref_result(1'b0, 32'h1234_5678, 32'h9ABC_DEF1);
    check("dz_keep_hi", 64'(hi_out), 64'(e[63:32]));
    check("dz_keep_lo", 64'(lo_out), 64'(e[31:0]));

    // start re-pulsed mid-RUN and in DONE is ignored.
    op = 1'b0; a = 32'h0000_1234; b = 32'hFFFF_5678; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      if (lat == 11) begin
        start = 1'b1; op = 1'b1; a = 32'd5; b = 32'd0;
      end else begin
        start = 1'b0; op = 1'b0; a = 32'd9; b = 32'd9;
      end
      @(posedge clock);
      #1;
      lat++;
    end
    start = 1'b0;
    e = ref_result(1'b0, 32'h0000_1234, 32'hFFFF_5678);
    m_hi = e[63:32];
    m_lo = e[31:0];
    check("repulse_lat", 64'(lat), 64'd33);
    check("repulse_dz", 64'(div_zero), 64'd0);
    check("repulse_hi", 64'(hi_out), 64'(m_hi));
    check("repulse_lo", 64'(lo_out), 64'(m_lo));
    start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd3;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("done_restart_busy", 64'(busy), 64'd0);
    check("done_restart_done", 64'(done), 64'd0);
    @(posedge clock);
    #1;
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_hi", 64'(hi_out), 64'(m_hi));
    run_op(1'b1, 32'hFFFF_FF00, 32'h0000_0007);

    // Asynchronous reset mid-RUN aborts and clears.
    op = 1'b0; a = 32'h0001_2345; b = 32'hFFFF_FFFD; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("arst_hi", 64'(hi_out), 64'd0);
    check("arst_lo", 64'(lo_out), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(posedge clock);
    #1;
    check("arst_nodone", 64'(done), 64'd0);
    reset = 1'b1;
    run_op(1'b0, 32'h0001_2345, 32'hFFFF_FFFD);

    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      run_op(r[0], pick(), pick());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
